if_stage_sram: RTL and testbench
================================

// Module: IF_Stage_sram
// PURPOSE
//   LoongArch pipeline fetch stage: the producer side of the IF->ID interface.
//   Issues instruction fetches on an SRAM-like req/addr_ok/data_ok bus and buffers
//   one instruction. Presents {inst, pc} to ID under the valid/allowin handshake.
//   Redirects on the single-cycle br_taken/br_target from ID and discards stale fetches.
// PARAMETERS
//   RESET_PC         32'h1c000000  address of first fetch after reset
//   IF_TO_ID_WIDTH   64            width of if_to_id_wire = {inst[31:0], pc[31:0]}
// PORTS
//   clk               in   1    single clock, all state on posedge
//   resetn            in   1    synchronous, active-low reset
//   id_allowin        in   1    ID can accept an instruction this cycle
//   br_taken          in   1    one-cycle redirect pulse from ID
//   br_target         in   32   redirect address, valid when br_taken=1
//   if_to_id_valid    out  1    if_to_id_wire holds a valid instruction
//   if_to_id_wire     out  64   {inst, pc}
//   inst_sram_req     out  1    fetch request
//   inst_sram_wr      out  1    constant 0
//   inst_sram_size    out  2    constant 2'd2 (word)
//   inst_sram_wstrb   out  4    constant 4'h0
//   inst_sram_addr    out  32   fetch address, word aligned
//   inst_sram_wdata   out  32   constant 0
//   inst_sram_addr_ok in   1    request accepted this cycle (when req=1)
//   inst_sram_data_ok in   1    read data returned this cycle
//   inst_sram_rdata   in   32   instruction word, valid with data_ok
// BEHAVIOUR
// - FSM states:
//   - REQ: req=1, addr=req_addr.
//   - WAIT: request accepted, awaiting data_ok.
//   - HOLD: inst_buf valid, offered to ID.
// - At most one outstanding request.
// - req_addr is latched on entry to REQ. It must not change, and req must not drop, until addr_ok.
// - Reset:
//   - State=REQ, req_addr=RESET_PC, pc_buf=0, inst_buf=0.
//   - cancel=0, br_pending=0.
//   - if_to_id_valid=0; req=1 in the first cycle after reset release.
// - Transitions:
//   - REQ & addr_ok -> WAIT. pc_buf <= req_addr.
//   - WAIT & data_ok & !cancel & !br_taken -> HOLD. inst_buf <= rdata.
//   - WAIT & data_ok & (cancel | br_taken) -> REQ. Data dropped, cancel <= 0.
//     - req_addr <= pending target (br_target if br_taken this cycle, else br_target_r).
//     - br_pending <= 0.
//   - HOLD & id_allowin & !br_taken -> REQ. req_addr <= pc_buf + 4 (mod 2^32).
//   - HOLD & br_taken -> REQ. Buffer dropped, req_addr <= br_target, no cancel.
// - if_to_id_valid = (state==HOLD). if_to_id_wire = {inst_buf, pc_buf}. Both are stable while ID stalls.
// - Fetch-to-valid latency: one cycle after data_ok. Best case one instruction per 3 cycles.
// - br_taken in REQ or WAIT without same-cycle data_ok:
//   - Sets cancel=1 and br_pending=1; br_target_r <= br_target.
//   - In REQ the current req/addr continue unchanged until addr_ok. That fetch is dropped.
// - br_taken in REQ with same-cycle addr_ok: the accepted request is stale; cancel=1.
// - A second br_taken while br_pending: the latest target wins.
// - br_taken in the same cycle as HOLD & id_allowin: the instruction counts as consumed by ID (which squashes it). The redirect still applies.
// - data_ok outside WAIT: ignored.
// - addr_ok outside REQ: ignored.
// - resetn low in any state: all state returns to reset values next edge; any in-flight response is not delivered.
// TESTING
// - Reset, addr_ok at cycle 2, data_ok at cycle 4 with rdata 0x02800c21 -> cycle 5: valid=1, wire={0x02800c21, 0x1c000000}.
// - HOLD with id_allowin=0 for 5 cycles -> valid and wire held; req=0. On allowin=1 -> next req addr 0x1c000004.
// - br_taken in HOLD, target 0x1c000100 -> next cycle valid=0, req=1, addr=0x1c000100.
// - br_taken in WAIT, target 0x1c000100, data_ok 2 cycles later -> never valid for that word; next req addr 0x1c000100.
// - br_taken in REQ with addr_ok low 3 cycles -> addr held at sequential 0x1c000008 until addr_ok; that data is dropped; then req 0x1c000100.
// - resetn=0 for 1 cycle during WAIT, then stale data_ok -> ignored; req addr 0x1c000000, valid stays 0.

Source files
------------

// File: rtl/if_stage_sram.sv
// Fetch stage: one-deep SRAM-bus fetcher feeding ID with {inst, pc}; valid one cycle after data_ok.
// Holds the buffered instruction while id_allowin is low; at most one request outstanding.
module if_stage_sram #(
    parameter logic [31:0] RESET_PC       = 32'h1c000000,
    parameter int          IF_TO_ID_WIDTH = 64
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      id_allowin,
    input  logic                      br_taken,
    input  logic [31:0]               br_target,
    output logic                      if_to_id_valid,
    output logic [IF_TO_ID_WIDTH-1:0] if_to_id_wire,
    output logic                      inst_sram_req,
    output logic                      inst_sram_wr,
    output logic [1:0]                inst_sram_size,
    output logic [3:0]                inst_sram_wstrb,
    output logic [31:0]               inst_sram_addr,
    output logic [31:0]               inst_sram_wdata,
    input  logic                      inst_sram_addr_ok,
    input  logic                      inst_sram_data_ok,
    input  logic [31:0]               inst_sram_rdata
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] req_addr;
    logic [31:0] pc_buf;
    logic [31:0] inst_buf;
    logic        cancel;
    logic        br_pending;
    logic [31:0] br_target_r;

    // A response that returns while a redirect is outstanding (or arrives with one) is stale.
    logic drop_rsp;
    assign drop_rsp = cancel | br_taken;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= S_REQ;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_REQ: begin
                if (inst_sram_addr_ok) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (inst_sram_data_ok) state_nxt = drop_rsp ? S_REQ : S_HOLD;
            end
            S_HOLD: begin
                if (br_taken || id_allowin) state_nxt = S_REQ;
            end
            default: state_nxt = S_REQ;
        endcase
    end

    always_comb begin
        inst_sram_req  = 1'b0;
        if_to_id_valid = 1'b0;
        case (state)
            S_REQ:   inst_sram_req  = 1'b1;
            S_HOLD:  if_to_id_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            req_addr    <= RESET_PC;
            pc_buf      <= 32'd0;
            inst_buf    <= 32'd0;
            cancel      <= 1'b0;
            br_pending  <= 1'b0;
            br_target_r <= 32'd0;
        end else begin
            case (state)
                S_REQ: begin
                    // The request in flight keeps its address; a redirect only marks it stale.
                    if (inst_sram_addr_ok) pc_buf <= req_addr;
                    if (br_taken) begin
                        cancel      <= 1'b1;
                        br_pending  <= 1'b1;
                        br_target_r <= br_target;
                    end
                end
                S_WAIT: begin
                    if (inst_sram_data_ok) begin
                        if (drop_rsp) begin
                            req_addr   <= br_taken ? br_target : br_target_r;
                            cancel     <= 1'b0;
                            br_pending <= 1'b0;
                        end else begin
                            inst_buf <= inst_sram_rdata;
                        end
                    end else if (br_taken) begin
                        cancel      <= 1'b1;
                        br_pending  <= 1'b1;
                        br_target_r <= br_target;
                    end
                end
                S_HOLD: begin
                    if (br_taken) begin
                        req_addr <= br_target;
                    end else if (id_allowin) begin
                        req_addr <= pc_buf + 32'd4;
                    end
                end
                default: ;
            endcase
        end
    end

    assign if_to_id_wire   = {inst_buf, pc_buf};
    assign inst_sram_addr  = req_addr;
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'd2;
    assign inst_sram_wstrb = 4'h0;
    assign inst_sram_wdata = 32'd0;

endmodule

// File: tb/tb_if_stage_sram.sv
// Directed bench for if_stage_sram: scoreboard of expected {inst, pc} deliveries plus
// cycle-level checks of the fetch bus around redirects, stalls and reset.
module tb_if_stage_sram;

    logic        clk = 1'b0;
    logic        resetn;
    logic        id_allowin;
    logic        br_taken;
    logic [31:0] br_target;
    logic        if_to_id_valid;
    logic [63:0] if_to_id_wire;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    int n_pass  = 0;
    int n_total = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    if_stage_sram dut (
        .clk               (clk),
        .resetn            (resetn),
        .id_allowin        (id_allowin),
        .br_taken          (br_taken),
        .br_target         (br_target),
        .if_to_id_valid    (if_to_id_valid),
        .if_to_id_wire     (if_to_id_wire),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_wr      (inst_sram_wr),
        .inst_sram_size    (inst_sram_size),
        .inst_sram_wstrb   (inst_sram_wstrb),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_wdata   (inst_sram_wdata),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are checked there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bus(input string name, input logic req, input logic [31:0] addr,
                             input logic valid);
        check({name, ".req"}, 64'(inst_sram_req), 64'(req));
        if (req) check({name, ".addr"}, 64'(inst_sram_addr), 64'(addr));
        check({name, ".valid"}, 64'(if_to_id_valid), 64'(valid));
    endtask

    // Accept the outstanding request this cycle.
    task automatic accept();
        inst_sram_addr_ok = 1'b1;
        tick();
        inst_sram_addr_ok = 1'b0;
    endtask

    task automatic respond(input logic [31:0] data);
        inst_sram_data_ok = 1'b1;
        inst_sram_rdata   = data;
        tick();
        inst_sram_data_ok = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] tgt);
        br_taken  = 1'b1;
        br_target = tgt;
        tick();
        br_taken  = 1'b0;
    endtask

    // Every ID handshake must match the oldest expected delivery.
    always @(negedge clk) begin
        if (resetn === 1'b1 && if_to_id_valid === 1'b1 && id_allowin === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL deliver: unexpected wire 0x%0h at %0t", if_to_id_wire, $time);
            end else begin
                check("deliver", if_to_id_wire, exp_q.pop_front());
            end
        end
    end

    initial begin
        resetn            = 1'b0;
        id_allowin        = 1'b0;
        br_taken          = 1'b0;
        br_target         = 32'd0;
        inst_sram_addr_ok = 1'b0;
        inst_sram_data_ok = 1'b0;
        inst_sram_rdata   = 32'd0;
        tick();
        tick();

        // Reset state and constant bus fields
        check_bus("rst", 1'b1, 32'h1c000000, 1'b0);
        check("rst.wire", if_to_id_wire, 64'd0);
        check("wr", 64'(inst_sram_wr), 64'd0);
        check("size", 64'(inst_sram_size), 64'd2);
        check("wstrb", 64'(inst_sram_wstrb), 64'd0);
        check("wdata", 64'(inst_sram_wdata), 64'd0);

        // First fetch: addr_ok at cycle 2, data_ok at cycle 4, valid at cycle 5
        resetn = 1'b1;
        tick();
        check_bus("c1", 1'b1, 32'h1c000000, 1'b0);
        accept();
        check_bus("c2.wait", 1'b0, 32'h0, 1'b0);
        tick();
        respond(32'h02800c21);
        check_bus("c5", 1'b0, 32'h0, 1'b1);
        check("c5.wire", if_to_id_wire, {32'h02800c21, 32'h1c000000});

        // ID stalls 5 cycles: output held, no new request
        for (int i = 0; i < 5; i++) begin
            tick();
            check_bus("stall", 1'b0, 32'h0, 1'b1);
            check("stall.wire", if_to_id_wire, {32'h02800c21, 32'h1c000000});
        end
        exp_q.push_back({32'h02800c21, 32'h1c000000});
        id_allowin = 1'b1;
        tick();
        id_allowin = 1'b0;
        check_bus("seq", 1'b1, 32'h1c000004, 1'b0);

        // Redirect while holding: buffered word is discarded, not delivered
        accept();
        respond(32'h0000aaaa);
        check("hold.wire", if_to_id_wire, {32'h0000aaaa, 32'h1c000004});
        redirect(32'h1c000100);
        check_bus("br_hold", 1'b1, 32'h1c000100, 1'b0);

        // Redirect while waiting: the late word must never reach ID
        id_allowin = 1'b1;
        accept();
        redirect(32'h1c000200);
        check_bus("br_wait", 1'b0, 32'h0, 1'b0);
        tick();
        respond(32'hdeadbeef);
        check_bus("br_wait.drop", 1'b1, 32'h1c000200, 1'b0);

        // Normal fetch at the target, consumed immediately
        accept();
        exp_q.push_back({32'h11111111, 32'h1c000200});
        respond(32'h11111111);
        tick();
        check_bus("after_tgt", 1'b1, 32'h1c000204, 1'b0);

        // Redirect in REQ with addr_ok low: address held; second redirect wins
        redirect(32'h1c000300);
        check_bus("br_req.0", 1'b1, 32'h1c000204, 1'b0);
        redirect(32'h1c000400);
        check_bus("br_req.1", 1'b1, 32'h1c000204, 1'b0);
        tick();
        check_bus("br_req.2", 1'b1, 32'h1c000204, 1'b0);
        accept();
        respond(32'hbad00001);
        check_bus("br_req.drop", 1'b1, 32'h1c000400, 1'b0);

        // Redirect in the same cycle as data_ok
        accept();
        br_taken  = 1'b1;
        br_target = 32'h1c000500;
        respond(32'hbad00002);
        br_taken  = 1'b0;
        check_bus("br_dok", 1'b1, 32'h1c000500, 1'b0);

        // Redirect in the same cycle as addr_ok
        br_taken  = 1'b1;
        br_target = 32'h1c000600;
        accept();
        br_taken  = 1'b0;
        respond(32'hbad00003);
        check_bus("br_aok", 1'b1, 32'h1c000600, 1'b0);

        // PC wraps modulo 2^32 on the sequential step
        accept();
        exp_q.push_back({32'h22222222, 32'h1c000600});
        respond(32'h22222222);
        tick();
        check_bus("pre_wrap", 1'b1, 32'h1c000604, 1'b0);
        accept();
        redirect(32'hfffffffc);
        tick();
        respond(32'hbad00004);
        check_bus("wrap.tgt", 1'b1, 32'hfffffffc, 1'b0);
        accept();
        exp_q.push_back({32'h33333333, 32'hfffffffc});
        respond(32'h33333333);
        tick();
        check_bus("wrap", 1'b1, 32'h00000000, 1'b0);

        // Reset during WAIT; the stale response afterwards is ignored
        accept();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        check_bus("rst_wait", 1'b1, 32'h1c000000, 1'b0);
        respond(32'hbad00005);
        check_bus("rst_stale", 1'b1, 32'h1c000000, 1'b0);
        accept();
        exp_q.push_back({32'h44444444, 32'h1c000000});
        respond(32'h44444444);
        tick();
        check_bus("rst_refetch", 1'b1, 32'h1c000004, 1'b0);

        id_allowin = 1'b0;
        tick();
        tick();
        check("pending_deliveries", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
